codec_slave_rsp: RTL and testbench

Serial-port responder for the CODEC audio interface: the CODEC-side end of the link that the equalizer's CODEC master drives. It sits in the testbench and FPGA loopback builds in place of the physical CODEC. It oversamples MCLK-domain SCL/LRCLK/SDin on the system clock, deserializes the master's 16-bit left/right samples, and serializes its own 16-bit samples back on SDout.

---
 rtl/codec_rsp_pkg.sv | 19 +
 rtl/codec_slave_rsp_sync_edge.sv | 39 +++
 rtl/codec_slave_rsp.sv | 180 ++++++++++++++++++
 tb/tb_codec_slave_rsp.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/codec_rsp_pkg.sv
// Shared types and constants for the CODEC serial-port responder.
package codec_rsp_pkg;

    localparam int unsigned SAMPLE_W_DEF = 16;

    function automatic int unsigned bit_cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // Counter must be able to hold the value SAMPLE_W itself
    localparam int unsigned BIT_CNT_W = $clog2(SAMPLE_W_DEF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rsp_state_t;

endpackage

// File: rtl/codec_slave_rsp_sync_edge.sv
// N-stage synchronizer with rise/fall pulse outputs.
// Edge pulses are masked until the chain has refilled after reset, so a
// pin that is already high when reset releases does not look like a rise.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic [STAGES:0]   primed;

    // Synchronizer chain, edge-history flop and post-reset priming mask
    always_ff @(posedge clk) begin
        if (rst) begin
            chain  <= '0;
            prev   <= 1'b0;
            primed <= '0;
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev   <= chain[STAGES-1];
            primed <= {primed[STAGES-1:0], 1'b1};
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = primed[STAGES] &  chain[STAGES-1] & ~prev;
    assign fall = primed[STAGES] & ~chain[STAGES-1] &  prev;

endmodule

// File: rtl/codec_slave_rsp.sv
// CODEC-side responder for the left-justified serial audio link.
// Optional build macro: CODEC_RSP_FRAME_CHK_EN enables the sticky
// half-frame bit-count checker driving frame_err.
module codec_slave_rsp
    import codec_rsp_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RSTn,
    input  logic                SCL,
    input  logic                LRCLK,
    input  logic                SDin,
    output logic                SDout,
    input  logic [SAMPLE_W-1:0] lft_tx,
    input  logic [SAMPLE_W-1:0] rht_tx,
    output logic                tx_req,
    output logic [SAMPLE_W-1:0] lft_rx,
    output logic [SAMPLE_W-1:0] rht_rx,
    output logic                rx_vld,
    output logic                frame_err
);

    localparam int unsigned      CNT_W    = bit_cnt_width(SAMPLE_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_W - 1);

    logic scl_rise, scl_fall, lr_rise, lr_fall, sdin_s, rstn_s;
    logic scl_q_unused, lr_q_unused;
    logic sdin_rise_unused, sdin_fall_unused, rstn_rise_unused, rstn_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_scl (
        .clk(clk), .rst(rst), .d(SCL),
        .q(scl_q_unused), .rise(scl_rise), .fall(scl_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrclk (
        .clk(clk), .rst(rst), .d(LRCLK),
        .q(lr_q_unused), .rise(lr_rise), .fall(lr_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdin (
        .clk(clk), .rst(rst), .d(SDin),
        .q(sdin_s), .rise(sdin_rise_unused), .fall(sdin_fall_unused)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rstn (
        .clk(clk), .rst(rst), .d(RSTn),
        .q(rstn_s), .rise(rstn_rise_unused), .fall(rstn_fall_unused)
    );

    rsp_state_t          state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [SAMPLE_W-1:0] rx_sh, rx_sh_n;
    logic [SAMPLE_W-1:0] left_word, left_word_n;
    logic [SAMPLE_W-1:0] tx_sh, tx_sh_n;
    logic [SAMPLE_W-1:0] rht_hold, rht_hold_n;
    logic [SAMPLE_W-1:0] lft_rx_n, rht_rx_n;
    logic                rx_vld_n;
    logic [SAMPLE_W-1:0] rx_shift_in, tx_shift;

    assign rx_shift_in = {rx_sh[SAMPLE_W-2:0], sdin_s};
    assign tx_shift    = {tx_sh[SAMPLE_W-2:0], 1'b0};
    assign SDout       = tx_sh[SAMPLE_W-1];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rx_sh     <= '0;
            left_word <= '0;
            tx_sh     <= '0;
            rht_hold  <= '0;
            lft_rx    <= '0;
            rht_rx    <= '0;
            rx_vld    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rx_sh     <= rx_sh_n;
            left_word <= left_word_n;
            tx_sh     <= tx_sh_n;
            rht_hold  <= rht_hold_n;
            lft_rx    <= lft_rx_n;
            rht_rx    <= rht_rx_n;
            rx_vld    <= rx_vld_n;
        end
    end

    // Next-state: LRCLK edges load the tx shifter and take priority over a
    // coincident SCL fall; SCL rises shift in data until SAMPLE_W bits.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rx_sh_n     = rx_sh;
        left_word_n = left_word;
        tx_sh_n     = tx_sh;
        rht_hold_n  = rht_hold;
        lft_rx_n    = lft_rx;
        rht_rx_n    = rht_rx;
        rx_vld_n    = 1'b0;
        tx_req      = 1'b0;

        if (!rstn_s) begin
            state_n = IDLE;
            cnt_n   = '0;
            rx_sh_n = '0;
            tx_sh_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lr_rise) begin
                        state_n    = LEFT;
                        rht_hold_n = rht_tx;
                        tx_sh_n    = lft_tx;
                        tx_req     = 1'b1;
                        cnt_n      = '0;
                        rx_sh_n    = '0;
                    end
                end
                LEFT: begin
                    if (lr_fall) begin
                        state_n     = RIGHT;
                        left_word_n = rx_sh;
                        tx_sh_n     = rht_hold;
                        cnt_n       = '0;
                        rx_sh_n     = '0;
                    end else if (scl_rise && cnt < CNT_FULL) begin
                        rx_sh_n = rx_shift_in;
                        cnt_n   = cnt + CNT_W'(1);
                    end else if (scl_fall) begin
                        tx_sh_n = tx_shift;
                    end
                end
                RIGHT: begin
                    if (lr_rise) begin
                        state_n    = LEFT;
                        rht_hold_n = rht_tx;
                        tx_sh_n    = lft_tx;
                        tx_req     = 1'b1;
                        cnt_n      = '0;
                        rx_sh_n    = '0;
                    end else if (scl_rise && cnt < CNT_FULL) begin
                        rx_sh_n = rx_shift_in;
                        cnt_n   = cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            lft_rx_n = left_word;
                            rht_rx_n = rx_shift_in;
                            rx_vld_n = 1'b1;
                        end
                    end else if (scl_fall) begin
                        tx_sh_n = tx_shift;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

`ifdef CODEC_RSP_FRAME_CHK_EN
    logic frame_err_q;

    // Sticky flag: a half-frame closed with a bit count other than SAMPLE_W
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else if (rstn_s && state != IDLE && (lr_rise || lr_fall) && cnt != CNT_FULL) begin
            frame_err_q <= 1'b1;
        end
    end

    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_codec_slave_rsp.sv
// Self-checking bench: an I2S-style master model drives frames, expected
// rx/tx words go into scoreboard queues, a monitor compares on DUT events.
module tb_codec_slave_rsp;

    logic        clk = 1'b0;
    logic        rst, RSTn, SCL, LRCLK, SDin, SDout, tx_req, rx_vld, frame_err;
    logic [15:0] lft_tx, rht_tx, lft_rx, rht_rx;

    always #10 clk = ~clk;

    codec_slave_rsp #(.SAMPLE_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .RSTn(RSTn), .SCL(SCL), .LRCLK(LRCLK),
        .SDin(SDin), .SDout(SDout), .lft_tx(lft_tx), .rht_tx(rht_tx),
        .tx_req(tx_req), .lft_rx(lft_rx), .rht_rx(rht_rx),
        .rx_vld(rx_vld), .frame_err(frame_err)
    );

`ifdef CODEC_RSP_FRAME_CHK_EN
    localparam logic FERR_EXP = 1'b1;
`else
    localparam logic FERR_EXP = 1'b0;
`endif

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        bit          chk_l;
        bit          spacing;
    } rx_exp_t;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    rx_exp_t rx_q[$];
    pair_t   tx_exp_q[$];
    pair_t   tx_cap_q[$];

    int n_chk      = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int tx_req_cnt = 0;
    int last_vld   = 0;
    bit sim_done   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents rx_vld, and
    // compares each master-captured tx pair against the loaded pair.
    initial begin : monitor
        rx_exp_t e;
        pair_t   a, b;
        while (!sim_done) begin
            @(negedge clk);
            if (tx_req === 1'b1) tx_req_cnt++;
            if (rx_vld === 1'b1) begin
                if (rx_q.size() == 0) begin
                    check("rx_vld_unexpected", 32'(rx_vld), 32'(0));
                end else begin
                    e = rx_q.pop_front();
                    if (e.chk_l) check("lft_rx", 32'(lft_rx), 32'(e.l));
                    check("rht_rx", 32'(rht_rx), 32'(e.r));
                    if (e.spacing) check("rx_vld_spacing", 32'(cyc - last_vld), 32'(1024));
                end
                last_vld = cyc;
            end
            while (tx_cap_q.size() > 0 && tx_exp_q.size() > 0) begin
                a = tx_cap_q.pop_front();
                b = tx_exp_q.pop_front();
                check("tx_left", 32'(a.l), 32'(b.l));
                check("tx_right", 32'(a.r), 32'(b.r));
            end
        end
    end

    // One 1024-clk frame: 16 SCL periods of 32 clk per half, data changes on
    // SCL fall, master captures SDout on SCL rise.
    // tx_mode: 0 = not checked, 1 = expect ltx/rtx, 2 = expect all zero.
    task automatic run_frame(input logic [15:0] l, input logic [15:0] r,
                             input logic [15:0] ltx, input logic [15:0] rtx,
                             input bit exp_rx, input bit chk_l, input bit spacing,
                             input int tx_mode, input int exp_txreq,
                             input int drop_bit, input int rst_bit);
        logic [15:0] word;
        logic [15:0] cap_l, cap_r;
        int          req0;
        rx_exp_t     e;
        pair_t       p;
        cap_l  = '0;
        cap_r  = '0;
        lft_tx = ltx;
        rht_tx = rtx;
        if (exp_rx) begin
            e.l = l; e.r = r; e.chk_l = chk_l; e.spacing = spacing;
            rx_q.push_back(e);
        end
        if (tx_mode == 1) begin
            p.l = ltx; p.r = rtx;
            tx_exp_q.push_back(p);
        end else if (tx_mode == 2) begin
            p.l = '0; p.r = '0;
            tx_exp_q.push_back(p);
        end
        req0 = tx_req_cnt;
        for (int h = 0; h < 2; h++) begin
            word  = (h == 0) ? l : r;
            LRCLK = (h == 0);
            for (int b = 0; b < 16; b++) begin
                SCL  = 1'b0;
                SDin = word[15-b];
                for (int c = 0; c < 16; c++) begin
                    @(negedge clk);
                    if (h == 0 && b == rst_bit) begin
                        if (c == 2) rst = 1'b1;
                        if (c == 5) begin
                            check("rst_SDout", 32'(SDout), 32'(0));
                            check("rst_lft_rx", 32'(lft_rx), 32'(0));
                            check("rst_rht_rx", 32'(rht_rx), 32'(0));
                            check("rst_rx_vld", 32'(rx_vld), 32'(0));
                            check("rst_tx_req", 32'(tx_req), 32'(0));
                            check("rst_frame_err", 32'(frame_err), 32'(0));
                            rst = 1'b0;
                        end
                    end
                end
                if (!(h == 0 && b == drop_bit)) begin
                    SCL = 1'b1;
                    if (h == 0) cap_l[15-b] = SDout;
                    else        cap_r[15-b] = SDout;
                end
                repeat (16) @(negedge clk);
            end
        end
        if (tx_mode != 0) begin
            p.l = cap_l; p.r = cap_r;
            tx_cap_q.push_back(p);
        end
        check("tx_req_per_frame", 32'(tx_req_cnt - req0), 32'(exp_txreq));
    endtask

    initial begin : stim
        rst    = 1'b1;
        RSTn   = 1'b1;
        SCL    = 1'b1;
        LRCLK  = 1'b0;
        SDin   = 1'b0;
        lft_tx = '0;
        rht_tx = '0;
        repeat (5) @(negedge clk);
        check("reset_SDout", 32'(SDout), 32'(0));
        check("reset_tx_req", 32'(tx_req), 32'(0));
        check("reset_lft_rx", 32'(lft_rx), 32'(0));
        check("reset_rht_rx", 32'(rht_rx), 32'(0));
        check("reset_rx_vld", 32'(rx_vld), 32'(0));
        check("reset_frame_err", 32'(frame_err), 32'(0));
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Directed loopback / transmit pattern
        run_frame(16'hA5C3, 16'h0F1E, 16'h8001, 16'h7FFE, 1, 1, 0, 1, 1, -1, -1);

        // Back-to-back random frames
        for (int i = 0; i < 8; i++) begin
            run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      1, 1, 1, 1, 1, -1, -1);
        end

        // Mid-frame rst: nothing received for this frame, resume on next rise
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  0, 0, 0, 0, 1, -1, 5);
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  1, 1, 0, 1, 1, -1, -1);

        // CODEC reset held low for two frames
        RSTn = 1'b0;
        repeat (40) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      0, 0, 0, 2, 0, -1, -1);
        end
        RSTn = 1'b1;
        repeat (40) @(negedge clk);
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  1, 1, 0, 1, 1, -1, -1);
        check("frame_err_before_drop", 32'(frame_err), 32'(0));

        // One SCL pulse missing in the left half
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  1, 0, 1, 0, 1, 7, -1);
        check("frame_err_after_drop", 32'(frame_err), 32'(FERR_EXP));
        run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  1, 1, 1, 1, 1, -1, -1);
        check("frame_err_sticky", 32'(frame_err), 32'(FERR_EXP));

        repeat (40) @(negedge clk);
        check("rx_expect_pending", 32'(rx_q.size()), 32'(0));
        check("tx_expect_pending", 32'(tx_exp_q.size()), 32'(0));
        sim_done = 1'b1;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
